// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the data-memory access arbiter:
//   - arb_state_e : sequencer states (IDLE / ACCESS / RESP)
//   - F3_*        : RISC-V load/store funct3 encodings
//   - NUM_PORTS   : number of requesters sharing the memory port
//   - access_fault: classifies a request as misaligned or illegal
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

  localparam int unsigned NUM_PORTS = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Returns 1 for a misaligned halfword/word access or an undefined funct3.
  // Stores only support the signed-size encodings (SB/SH/SW).
  function automatic logic access_fault(input logic       we,
                                        input logic [2:0] f3,
                                        input logic [1:0] addr_lsb);
    logic fault;
    fault = 1'b0;
    if (we) begin
      case (f3)
        F3_B:    fault = 1'b0;
        F3_H:    fault = addr_lsb[0];
        F3_W:    fault = |addr_lsb;
        default: fault = 1'b1;
      endcase
    end else begin
      case (f3)
        F3_B, F3_BU: fault = 1'b0;
        F3_H, F3_HU: fault = addr_lsb[0];
        F3_W:        fault = |addr_lsb;
        default:     fault = 1'b1;
      endcase
    end
    return fault;
  endfunction

endpackage

// File: rtl/dmem_rr_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_rr_arbiter
// Two-way round-robin grant. The grant is combinational from the request
// vector and the last granted port; only last_grant is stored.
//   clk         : clock
//   rst_n       : asynchronous active-low reset (last_grant resets to port 1,
//                 so port 0 wins the first tie)
//   req_valid_i : per-port request valid
//   advance_i   : a grant was accepted this cycle; remember who got it
//   grant_o     : one-hot grant (all zero when nobody requests)
// -----------------------------------------------------------------------------
module dmem_rr_arbiter
  import dmem_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req_valid_i,
  input  logic                 advance_i,
  output logic [NUM_PORTS-1:0] grant_o
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    grant_o = '0;
    case (req_valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      // On a tie the port that was not served last time wins.
      2'b11:   grant_o = last_grant_q ? 2'b01 : 2'b10;
      default: grant_o = '0;
    endcase
  end

  // The grant is one-hot whenever advance_i is set, so bit 1 is the index.
  assign last_grant_d = advance_i ? grant_o[1] : last_grant_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/dmem_access_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_access_arbiter
// Shares the single data-memory port between the core load/store path (port 0)
// and a DMA/debug requester (port 1). One access is in flight at a time:
// IDLE accepts a request, ACCESS drives the memory for one cycle, RESP holds
// the response until the owning port consumes it.
//
// Optional feature macro: DMEM_ARB_ALIGN_CHECK_EN
//   defined   : misaligned/illegal requests skip ACCESS and respond with
//               rsp_err = 1 and rsp_rdata = 0
//   undefined : every request is issued as-is, rsp_err stays 0
//
// Ports (port i uses bit i / slice i of every per-port vector):
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : request handshake per port
//   req_we, req_funct3  : store flag and funct3 per port
//   req_addr, req_wdata : byte address and raw store data per port
//   rsp_valid/rsp_ready : response handshake per port
//   rsp_rdata, rsp_err  : shared load result and error flag
//   mem_read/mem_write  : one-cycle strobes to the memory unit
//   mem_funct3/addr/wdata : command register contents to the memory unit
//   mem_rdata           : combinational load data from the memory unit
// -----------------------------------------------------------------------------
module dmem_access_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          req_valid,
  output logic [NUM_PORTS-1:0]          req_ready,
  input  logic [NUM_PORTS-1:0]          req_we,
  input  logic [3*NUM_PORTS-1:0]        req_funct3,
  input  logic [ADDR_W*NUM_PORTS-1:0]   req_addr,
  input  logic [DATA_W*NUM_PORTS-1:0]   req_wdata,
  output logic [NUM_PORTS-1:0]          rsp_valid,
  input  logic [NUM_PORTS-1:0]          rsp_ready,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          rsp_err,
  output logic                          mem_read,
  output logic                          mem_write,
  output logic [2:0]                    mem_funct3,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata
);

  arb_state_e state_q;

  // Command register
  logic              cmd_we_q;
  logic [2:0]        cmd_f3_q;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic [DATA_W-1:0] cmd_wdata_q;
  logic              cmd_port_q;

  // Registered outputs
  logic                 mem_read_q;
  logic                 mem_write_q;
  logic [NUM_PORTS-1:0] rsp_valid_q;
  logic [DATA_W-1:0]    rsp_rdata_q;
  logic                 rsp_err_q;

  // Arbitration / selection
  logic [NUM_PORTS-1:0] grant;
  logic                 handshake;
  logic                 gidx;
  logic                 sel_we;
  logic [2:0]           sel_f3;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic                 sel_fault;

  dmem_rr_arbiter u_rr_arbiter (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .advance_i   (handshake),
    .grant_o     (grant)
  );

  // Grants are only offered while idle; the grant already implies req_valid.
  assign req_ready = (state_q == IDLE) ? grant : '0;
  assign handshake = |req_ready;
  assign gidx      = grant[1];

  assign sel_we    = req_we[gidx];
  assign sel_f3    = gidx ? req_funct3[5:3] : req_funct3[2:0];
  assign sel_addr  = gidx ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
  assign sel_wdata = gidx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  assign sel_fault = access_fault(sel_we, sel_f3, sel_addr[1:0]);
`else
  assign sel_fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_we_q    <= 1'b0;
      cmd_f3_q    <= '0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_port_q  <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (handshake) begin
            cmd_we_q    <= sel_we;
            cmd_f3_q    <= sel_f3;
            cmd_addr_q  <= sel_addr;
            cmd_wdata_q <= sel_wdata;
            cmd_port_q  <= gidx;
            if (sel_fault) begin
              // Faulting requests never touch memory: answer directly.
              state_q     <= RESP;
              rsp_valid_q <= grant;
              rsp_rdata_q <= '0;
              rsp_err_q   <= 1'b1;
            end else begin
              // Strobes are registered here so they are high for exactly
              // the ACCESS cycle.
              state_q     <= ACCESS;
              mem_write_q <= sel_we;
              mem_read_q  <= ~sel_we;
            end
          end
        end
        ACCESS: begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          rsp_rdata_q <= cmd_we_q ? '0 : mem_rdata;
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= cmd_port_q ? 2'b10 : 2'b01;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready[cmd_port_q]) begin
            rsp_valid_q <= '0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_funct3 = cmd_f3_q;
  assign mem_addr   = cmd_addr_q;
  assign mem_wdata  = cmd_wdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_access_arbiter
// Self-checking bench for dmem_access_arbiter. Contains a byte-array memory
// unit that the DUT drives, and an independent byte-array reference that
// predicts every response from the load/store rules.
// -----------------------------------------------------------------------------
module tb_dmem_access_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req_valid = '0;
  logic [1:0]    req_ready;
  logic [1:0]    req_we = '0;
  logic [5:0]    req_funct3 = '0;
  logic [63:0]   req_addr = '0;
  logic [63:0]   req_wdata = '0;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready = '0;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          mem_read;
  logic          mem_write;
  logic [2:0]    mem_funct3;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  int errors = 0;
  int checks = 0;
  int tb_last = 1;

  always #5 clk = ~clk;

  dmem_access_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_funct3 (mem_funct3),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // ---------------- memory unit (64 bytes, little-endian, wraps) ----------
  logic [7:0] dmem [64] = '{default: 8'h00};
  logic [7:0] refm [64] = '{default: 8'h00};
  logic [5:0] ma;
  assign ma = mem_addr[5:0];

  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [31:0] raw);
    case (f3)
      3'b000:  return {{24{raw[7]}}, raw[7:0]};
      3'b100:  return {24'h0, raw[7:0]};
      3'b001:  return {{16{raw[15]}}, raw[15:0]};
      3'b101:  return {16'h0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  always_comb begin
    mem_rdata = fmt_load(mem_funct3, {dmem[ma + 6'd3], dmem[ma + 6'd2], dmem[ma + 6'd1], dmem[ma]});
  end

  always @(posedge clk) begin
    if (mem_write) begin
      dmem[ma] <= mem_wdata[7:0];
      if (mem_funct3[1:0] != 2'b00) dmem[ma + 6'd1] <= mem_wdata[15:8];
      if (mem_funct3[1:0] == 2'b10) begin
        dmem[ma + 6'd2] <= mem_wdata[23:16];
        dmem[ma + 6'd3] <= mem_wdata[31:24];
      end
    end
  end

  // ---------------- reference model ----------------------------------------
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [5:0] b;
    b = a[5:0];
    return fmt_load(f3, {refm[b + 6'd3], refm[b + 6'd2], refm[b + 6'd1], refm[b]});
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int unsigned nbytes;
    logic [5:0] b;
    nbytes = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b10) ? 4 : 2;
    for (int unsigned i = 0; i < nbytes; i++) begin
      b = a[5:0] + 6'(i);
      refm[b] = wd[8*i +: 8];
    end
  endtask

  // Misaligned: address not a multiple of the access size. Illegal: stores
  // other than B/H/W, loads other than B/H/W/BU/HU.
  function automatic bit exp_bad(input logic we, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    int unsigned size;
    if (we) legal = (f3 <= 3'd2);
    else    legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    size = 1 << f3[1:0];
    return ALIGN_EN && (!legal || ((a % size) != 0));
  endfunction

  // ---------------- checking helpers ---------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req_ready"},  32'(req_ready),  32'd0);
    chk({tag, "_rsp_valid"},  32'(rsp_valid),  32'd0);
    chk({tag, "_mem_read"},   32'(mem_read),   32'd0);
    chk({tag, "_mem_write"},  32'(mem_write),  32'd0);
    chk({tag, "_rsp_rdata"},  rsp_rdata,       32'd0);
    chk({tag, "_rsp_err"},    32'(rsp_err),    32'd0);
    chk({tag, "_mem_addr"},   mem_addr,        32'd0);
    chk({tag, "_mem_wdata"},  mem_wdata,       32'd0);
    chk({tag, "_mem_funct3"}, 32'(mem_funct3), 32'd0);
  endtask

  task automatic set_req(input int p, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
    req_valid[p]          = 1'b1;
    req_we[p]             = we;
    req_funct3[p*3 +: 3]  = f3;
    req_addr[p*32 +: 32]  = a;
    req_wdata[p*32 +: 32] = wd;
  endtask

  task automatic rand_req(input int p);
    int unsigned sz;
    logic we;
    logic [2:0] f3;
    logic [31:0] a;
    sz = $urandom_range(0, 2);
    we = 1'($urandom_range(0, 1));
    f3 = 3'(sz);
    if (!we && sz < 2 && $urandom_range(0, 1) == 1) f3[2] = 1'b1;
    a = 32'($urandom_range(0, 15) * 4);
    if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
    set_req(p, we, f3, a, $urandom);
  endtask

  // Serves one access on port p, which must be the expected grant this cycle.
  // hold: cycles rsp_ready stays low in RESP. keep: p re-requests right after
  // its handshake. other: the opposite port starts requesting at that point.
  task automatic serve(input int p, input int hold, input bit keep, input bit other);
    logic we;
    logic [2:0] f3;
    logic [31:0] a, wd, exp_rd;
    logic [1:0] oh;
    bit bad;
    #1;
    oh = (p == 1) ? 2'b10 : 2'b01;
    we = req_we[p];
    f3 = req_funct3[p*3 +: 3];
    a  = req_addr[p*32 +: 32];
    wd = req_wdata[p*32 +: 32];
    bad = exp_bad(we, f3, a);
    exp_rd = '0;
    if (!bad && !we) exp_rd = ref_load(f3, a);
    if (!bad && we) ref_store(f3, a, wd);
    chk("grant", 32'(req_ready), 32'(oh));
    tb_last = p;

    @(negedge clk);
    if (keep) rand_req(p);
    else req_valid[p] = 1'b0;
    if (other) rand_req(1 - p);
    #1;
    if (bad) begin
      chk("err_rsp_valid", 32'(rsp_valid), 32'(oh));
      chk("err_flag", 32'(rsp_err), 32'd1);
      chk("err_no_strobe", 32'({mem_read, mem_write}), 32'd0);
    end else begin
      chk("mem_write", 32'(mem_write), 32'(we));
      chk("mem_read", 32'(mem_read), 32'(!we));
      chk("mem_addr", mem_addr, a);
      chk("mem_funct3", 32'(mem_funct3), 32'(f3));
      chk("mem_wdata", mem_wdata, wd);
      chk("rsp_early", 32'(rsp_valid), 32'd0);
      chk("ready_busy_acc", 32'(req_ready), 32'd0);
      @(negedge clk);
      #1;
    end

    for (int h = 0; h <= hold; h++) begin
      if (h == hold) rsp_ready[p] = 1'b1;
      else rsp_ready[1 - p] = 1'b1;
      chk("rsp_valid", 32'(rsp_valid), 32'(oh));
      chk("rsp_rdata", rsp_rdata, exp_rd);
      chk("rsp_err", 32'(rsp_err), 32'(bad));
      chk("strobe_off", 32'({mem_read, mem_write}), 32'd0);
      chk("ready_busy_rsp", 32'(req_ready), 32'd0);
      if (h != hold) begin
        @(negedge clk);
        #1;
      end
    end

    @(negedge clk);
    rsp_ready = '0;
    #1;
    chk("rsp_done", 32'(rsp_valid), 32'd0);
  endtask

  // ---------------- stimulus ------------------------------------------------
  initial begin
    repeat (2) @(negedge clk);
    #1;
    check_reset("por");

    // Port 0 store then load of the same word.
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 1'b1, 3'b010, 32'h0, 32'hDEAD_BEEF);
    serve(0, 0, 1'b0, 1'b0);
    set_req(0, 1'b0, 3'b010, 32'h0, 32'h0);
    serve(0, 0, 1'b0, 1'b0);

    // Port 1 byte store, then a reset so the next tie starts fresh.
    set_req(1, 1'b1, 3'b000, 32'h8, 32'h1234_56AA);
    serve(1, 0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tb_last = 1;
    #1;
    check_reset("rst2");
    @(negedge clk);
    rst_n = 1'b1;

    // Simultaneous requests: port 0 first, then port 1.
    set_req(0, 1'b0, 3'b010, 32'h0, 32'h0);
    set_req(1, 1'b0, 3'b100, 32'h8, 32'h0);
    serve(0, 0, 1'b0, 1'b0);
    serve(1, 0, 1'b0, 1'b0);

    // Port 1 LB held for 5 cycles while port 0 waits.
    set_req(1, 1'b0, 3'b000, 32'h8, 32'h0);
    serve(1, 5, 1'b0, 1'b1);
    serve(0, 0, 1'b0, 1'b0);

    // Misaligned halfword store, then read back the surrounding word.
    set_req(0, 1'b1, 3'b001, 32'h5, 32'h0000_5A5A);
    serve(0, 1, 1'b0, 1'b0);
    set_req(0, 1'b0, 3'b010, 32'h4, 32'h0);
    serve(0, 0, 1'b0, 1'b0);
    set_req(1, 1'b0, 3'b010, 32'h2, 32'h0);
    serve(1, 0, 1'b0, 1'b0);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    set_req(1, 1'b0, 3'b110, 32'h10, 32'h0);
    serve(1, 0, 1'b0, 1'b0);
    set_req(0, 1'b1, 3'b011, 32'h10, 32'hFFFF_FFFF);
    serve(0, 2, 1'b0, 1'b0);
    set_req(0, 1'b0, 3'b010, 32'h10, 32'h0);
    serve(0, 0, 1'b0, 1'b0);
`endif

    // Reset during the ACCESS cycle of a store.
    set_req(0, 1'b1, 3'b010, 32'hC, 32'h1234_5678);
    serve(0, 0, 1'b0, 1'b0);
    set_req(0, 1'b1, 3'b010, 32'hC, 32'hCAFE_F00D);
    #1;
    chk("rst_acc_grant", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("rst_acc_write", 32'(mem_write), 32'd1);
    #1;
    rst_n = 1'b0;
    tb_last = 1;
    #1;
    check_reset("rst_acc");
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 1'b0, 3'b010, 32'hC, 32'h0);
    serve(0, 0, 1'b0, 1'b0);

    // Both ports continuously valid with random traffic: grants alternate.
    rand_req(0);
    rand_req(1);
    for (int i = 0; i < 24; i++) begin
      serve(1 - tb_last, $urandom_range(0, 2), 1'b1, 1'b0);
    end
    req_valid = '0;

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
